seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 106 ++++++++++
 tb/tb_seg7_scan_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Purpose: time-multiplexes four hex digits onto a shared 7-seg decoder with per-slot dead time and frame-aligned updates.
// Latency: a loaded value reaches the display at the next frame boundary; ack pulses the cycle after that boundary.
// Backpressure: none; a newer load before the boundary replaces the pending value, and only one ack is issued.
module seg7_scan_ctrl #(
  parameter int CLK_DIV = 50000,
  parameter int GUARD   = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  digit_en,
  input  logic        blank_lz,
  output logic [3:0]  dig_e,
  output logic        dig_enable,
  output logic [3:0]  an,
  output logic        ack
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   disp;
  logic [15:0]   pend;
  logic          pflag;

  logic          slot_end;
  logic          frame_end;
  logic          guard_ph;
  logic [3:0]    cur_nib;
  logic          lz_blank;
  logic          zero_run;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == 2'd3);
  assign guard_ph  = (cnt < GUARD_CNT);
  assign cur_nib   = disp[{idx, 2'b00} +: 4];

  // Slot timer and digit index: one slot per CLK_DIV cycles, four slots per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Load capture and frame-boundary commit; disp only changes at the frame boundary so digits never tear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp  <= 16'h0000;
      pend  <= 16'h0000;
      pflag <= 1'b0;
      ack   <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (frame_end) begin
        if (load) begin
          // A load landing on the boundary itself goes straight to the display.
          disp  <= value;
          pend  <= value;
          pflag <= 1'b0;
          ack   <= 1'b1;
        end else if (pflag) begin
          disp  <= pend;
          pflag <= 1'b0;
          ack   <= 1'b1;
        end
      end else if (load) begin
        pend  <= value;
        pflag <= 1'b1;
      end
    end
  end

  // Leading-zero detection: the current digit is blanked when it and every digit to its left are zero; digit 0 always shows.
  always_comb begin
    lz_blank = 1'b0;
    zero_run = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      zero_run = zero_run & (disp[4*i +: 4] == 4'd0);
      if (idx == 2'(i)) begin
        lz_blank = blank_lz & zero_run;
      end
    end
  end

  // Digit drive: anodes and decoder stay off in the dead-time phase and while reset is held.
  always_comb begin
    an         = 4'hF;
    dig_enable = 1'b0;
    dig_e      = cur_nib;
    if (!rst && !guard_ph) begin
      an[idx]    = 1'b0;
      dig_enable = digit_en[idx] & ~lz_blank;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Purpose: directed check of seg7_scan_ctrl with CLK_DIV=8, GUARD=2.
// Latency: positions are tracked in cycles since reset release (pos); frame = 32 cycles.
// Backpressure: not applicable; stimulus is a fixed linear schedule.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  digit_en;
  logic        blank_lz;
  logic [3:0]  dig_e;
  logic        dig_enable;
  logic [3:0]  an;
  logic        ack;

  int errors  = 0;
  int checks  = 0;
  int pos     = 0;
  int ack_cnt = 0;
  int base    = 0;

  logic [3:0] an_exp [16] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE,
                              4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD};
  logic       en_exp [16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                              1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.CLK_DIV(8), .GUARD(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .load       (load),
    .digit_en   (digit_en),
    .blank_lz   (blank_lz),
    .dig_e      (dig_e),
    .dig_enable (dig_enable),
    .an         (an),
    .ack        (ack)
  );

  // Count ack pulses as seen at each rising edge.
  always @(posedge clk) if (ack === 1'b1) ack_cnt++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
    pos++;
  endtask

  task automatic go(input int p);
    while (pos < p) step();
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = 16'h0000; digit_en = 4'hF; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_dig_enable", {15'h0, dig_enable}, 16'h0000);
    chk("rst_dig_e", {12'h0, dig_e}, 16'h0000);
    chk("rst_ack", {15'h0, ack}, 16'h0000);

    // Release: first cycle is the dead time of digit 0.
    rst = 1'b0; pos = 0;
    #1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("scan_an_%0d", k), {12'h0, an}, {12'h0, an_exp[k]});
      chk($sformatf("scan_en_%0d", k), {15'h0, dig_enable}, {15'h0, en_exp[k]});
      chk($sformatf("scan_dig_e_%0d", k), {12'h0, dig_e}, 16'h0000);
      step();
    end

    // Load 1A3F during digit 1 of frame 1; commit at pos 63.
    go(40); value = 16'h1A3F; load = 1'b1; step(); load = 1'b0;
    base = ack_cnt;
    go(63);
    chk("pre_commit_ack", {15'h0, ack}, 16'h0000);
    chk("pre_commit_dig_e", {12'h0, dig_e}, 16'h0000);
    step();
    chk("commit_ack", {15'h0, ack}, 16'h0001);
    step();
    chk("commit_ack_low", {15'h0, ack}, 16'h0000);
    go(66); chk("show_d0", {12'h0, dig_e}, 16'h000F);
    go(74); chk("show_d1", {12'h0, dig_e}, 16'h0003);
    go(82); chk("show_d2", {12'h0, dig_e}, 16'h000A);
    go(90); chk("show_d3", {12'h0, dig_e}, 16'h0001);
    go(96); chk("ack_once", 16'(ack_cnt - base), 16'h0001);

    // Two loads in one frame: newest wins, one ack.
    go(100); value = 16'h1111; load = 1'b1; step(); load = 1'b0;
    go(110); value = 16'h2222; load = 1'b1; step(); load = 1'b0;
    base = ack_cnt;
    go(126); chk("no_tear_d3", {12'h0, dig_e}, 16'h0001);
    go(130); chk("newest_ack_once", 16'(ack_cnt - base), 16'h0001);
    chk("newest_d0", {12'h0, dig_e}, 16'h0002);
    go(138); chk("newest_d1", {12'h0, dig_e}, 16'h0002);
    go(146); chk("newest_d2", {12'h0, dig_e}, 16'h0002);
    go(154); chk("newest_d3", {12'h0, dig_e}, 16'h0002);

    // Leading-zero blanking with 0050.
    go(160); value = 16'h0050; load = 1'b1; step(); load = 1'b0;
    go(192); blank_lz = 1'b1;
    go(194); chk("lz50_d0", {15'h0, dig_enable}, 16'h0001);
    go(195); digit_en = 4'hE; #1;
    chk("digit_en_gate", {15'h0, dig_enable}, 16'h0000);
    digit_en = 4'hF; #1;
    chk("digit_en_ungate", {15'h0, dig_enable}, 16'h0001);
    go(202); chk("lz50_d1", {15'h0, dig_enable}, 16'h0001);
    chk("lz50_d1_val", {12'h0, dig_e}, 16'h0005);
    go(210); chk("lz50_d2", {15'h0, dig_enable}, 16'h0000);
    go(218); chk("lz50_d3", {15'h0, dig_enable}, 16'h0000);

    // All-zero display: only digit 0 stays lit.
    go(220); value = 16'h0000; load = 1'b1; step(); load = 1'b0;
    go(224); chk("lz0_guard", {15'h0, dig_enable}, 16'h0000);
    go(226); chk("lz0_d0", {15'h0, dig_enable}, 16'h0001);
    go(234); chk("lz0_d1", {15'h0, dig_enable}, 16'h0000);
    blank_lz = 1'b0; #1;
    chk("lz_off_d1", {15'h0, dig_enable}, 16'h0001);
    blank_lz = 1'b1;
    go(242); chk("lz0_d2", {15'h0, dig_enable}, 16'h0000);
    go(250); chk("lz0_d3", {15'h0, dig_enable}, 16'h0000);

    // Load coincident with the commit cycle.
    go(255); blank_lz = 1'b0; value = 16'hBEEF; load = 1'b1;
    base = ack_cnt;
    step(); load = 1'b0;
    chk("coinc_ack", {15'h0, ack}, 16'h0001);
    step();
    chk("coinc_ack_low", {15'h0, ack}, 16'h0000);
    go(258); chk("beef_d0", {12'h0, dig_e}, 16'h000F);
    chk("beef_en", {15'h0, dig_enable}, 16'h0001);
    go(266); chk("beef_d1", {12'h0, dig_e}, 16'h000E);
    go(274); chk("beef_d2", {12'h0, dig_e}, 16'h000E);
    go(282); chk("beef_d3", {12'h0, dig_e}, 16'h000B);
    go(290); chk("coinc_ack_once", 16'(ack_cnt - base), 16'h0001);

    // Reset mid-drive with a pending load.
    value = 16'h1234; load = 1'b1; step(); load = 1'b0;
    step();
    chk("pre_rst_an", {12'h0, an}, 16'h000E);
    rst = 1'b1; #1;
    chk("midrst_an", {12'h0, an}, 16'h000F);
    chk("midrst_en", {15'h0, dig_enable}, 16'h0000);
    chk("midrst_ack", {15'h0, ack}, 16'h0000);
    base = ack_cnt;
    step(); step();
    chk("held_rst_an", {12'h0, an}, 16'h000F);
    rst = 1'b0; pos = 0; #1;
    chk("post_rst_guard_an", {12'h0, an}, 16'h000F);
    go(2);
    chk("post_rst_an", {12'h0, an}, 16'h000E);
    chk("post_rst_dig_e", {12'h0, dig_e}, 16'h0000);
    go(34);
    chk("post_rst_no_ack", 16'(ack_cnt - base), 16'h0000);
    chk("post_rst_d0", {12'h0, dig_e}, 16'h0000);
    go(58); chk("post_rst_d3", {12'h0, dig_e}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
